// File: rtl/mul_sequencer.sv
// Control sequencer for the shift-add multiplier datapath: clear, load multiplier,
// WIDTH add/shift iterations, then hand the product to the S-bus once granted.
module mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic CLK,
  input  logic CLR,
  input  logic start,
  input  logic abort,
  input  logic s_grant,
  input  logic q_lsb,
  input  logic a_lsb,
  input  logic carry,
  output logic busy,
  output logic done,
  output logic s_req,
  output logic AND1_sw,
  output logic AND2_sw,
  output logic x_in,
  output logic u_in,
  output logic MUX1_sw,
  output logic MUX2_sw,
  output logic A_RW,
  output logic Q_RW,
  output logic A_CLK,
  output logic Q_CLK,
  output logic A_CLR,
  output logic Q_CLR,
  output logic ALS_mul
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOADQ, ADD, SHIFT, XFER
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_cq;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cq    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        CLEAR: begin
          r_cnt <= '0;
          r_cq  <= 1'b0;
        end
        ADD:   r_cq <= q_lsb & carry;
        // Hold at the terminal count; only CLEAR brings it back to zero.
        SHIFT: if (!w_last) r_cnt <= r_cnt + CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start && !abort) w_next = CLEAR;
      CLEAR:   w_next = LOADQ;
      LOADQ:   w_next = ADD;
      ADD:     w_next = SHIFT;
      SHIFT:   w_next = w_last ? XFER : ADD;
      XFER:    if (s_grant) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort && r_state != IDLE) w_next = IDLE;
  end

  always_comb begin
    busy    = (r_state != IDLE);
    done    = 1'b0;
    s_req   = 1'b0;
    AND1_sw = 1'b0;
    AND2_sw = 1'b0;
    x_in    = 1'b0;
    u_in    = 1'b0;
    MUX1_sw = 1'b0;
    MUX2_sw = 1'b0;
    A_RW    = 1'b0;
    Q_RW    = 1'b0;
    A_CLK   = 1'b0;
    Q_CLK   = 1'b0;
    A_CLR   = 1'b0;
    Q_CLR   = 1'b0;
    ALS_mul = 1'b0;
    case (r_state)
      CLEAR: begin
        A_CLR = 1'b1;
        Q_CLR = 1'b1;
      end
      LOADQ: begin
        Q_RW  = 1'b1;
        Q_CLK = 1'b1;
      end
      ADD: if (q_lsb) begin
        AND1_sw = 1'b1;
        A_RW    = 1'b1;
        A_CLK   = 1'b1;
      end
      SHIFT: begin
        MUX1_sw = 1'b1;
        MUX2_sw = 1'b1;
        A_CLK   = 1'b1;
        Q_CLK   = 1'b1;
        u_in    = r_cq;
        x_in    = a_lsb;
      end
      XFER: begin
        s_req   = 1'b1;
        AND2_sw = 1'b1;
        // A same-cycle abort suppresses the transfer.
        ALS_mul = s_grant && !abort;
        done    = s_grant && !abort;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: per-cycle expected control vectors derived from
// the documented cycle timeline, plus scenario-level latency and strobe counts.
module tb_mul_sequencer;

  localparam int W = 16;
  localparam int S_IDLE = 0, S_CLEAR = 1, S_LOADQ = 2, S_ADD = 3, S_SHIFT = 4, S_XFER = 5;

  logic CLK = 1'b0;
  logic CLR, start, abort, s_grant, q_lsb, a_lsb, carry;
  logic busy, done, s_req, AND1_sw, AND2_sw, x_in, u_in, MUX1_sw, MUX2_sw;
  logic A_RW, Q_RW, A_CLK, Q_CLK, A_CLR, Q_CLR, ALS_mul;
  logic [15:0] w_outs;

  int  checks = 0;
  int  failures = 0;
  logic m_cq = 1'b0;

  always #5 CLK = ~CLK;

  mul_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .abort(abort), .s_grant(s_grant),
    .q_lsb(q_lsb), .a_lsb(a_lsb), .carry(carry),
    .busy(busy), .done(done), .s_req(s_req), .AND1_sw(AND1_sw), .AND2_sw(AND2_sw),
    .x_in(x_in), .u_in(u_in), .MUX1_sw(MUX1_sw), .MUX2_sw(MUX2_sw),
    .A_RW(A_RW), .Q_RW(Q_RW), .A_CLK(A_CLK), .Q_CLK(Q_CLK),
    .A_CLR(A_CLR), .Q_CLR(Q_CLR), .ALS_mul(ALS_mul)
  );

  assign w_outs = {busy, done, s_req, AND1_sw, AND2_sw, x_in, u_in, MUX1_sw, MUX2_sw,
                   A_RW, Q_RW, A_CLK, Q_CLK, A_CLR, Q_CLR, ALS_mul};

  // State expected c cycles after a start, with `stall` grant-wait cycles in XFER.
  function automatic int sched(input int c, input int stall);
    if (c <= 0)                return S_IDLE;
    if (c == 1)                return S_CLEAR;
    if (c == 2)                return S_LOADQ;
    if (c <= 2 + 2*W)          return ((c - 3) % 2 == 0) ? S_ADD : S_SHIFT;
    if (c <= 3 + 2*W + stall)  return S_XFER;
    return S_IDLE;
  endfunction

  function automatic logic [15:0] exp_vec(input int st, input logic ql, input logic cq,
                                          input logic al, input logic gr, input logic ab);
    logic [15:0] e;
    e = '0;
    case (st)
      S_CLEAR: begin e[15] = 1'b1; e[2] = 1'b1; e[1] = 1'b1; end
      S_LOADQ: begin e[15] = 1'b1; e[5] = 1'b1; e[3] = 1'b1; end
      S_ADD: begin
        e[15] = 1'b1;
        if (ql) begin e[12] = 1'b1; e[6] = 1'b1; e[4] = 1'b1; end
      end
      S_SHIFT: begin
        e[15] = 1'b1; e[10] = al; e[9] = cq; e[8] = 1'b1; e[7] = 1'b1;
        e[4] = 1'b1; e[3] = 1'b1;
      end
      S_XFER: begin
        e[15] = 1'b1; e[13] = 1'b1; e[11] = 1'b1;
        e[14] = gr & ~ab; e[0] = gr & ~ab;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Datapath stand-in: q_lsb walks the multiplier bits, carry follows cpat.
  task automatic drive(input int st, input int rc, input int stall,
                       input logic [15:0] mult, input logic [15:0] cpat);
    int k;
    k = (rc - 3) / 2;
    start = 1'b0;
    abort = 1'b0;
    if (st == S_ADD) begin
      q_lsb = mult[k];
      carry = cpat[k];
      m_cq  = mult[k] & cpat[k];
    end else begin
      q_lsb = 1'($urandom_range(0, 1));
      carry = 1'($urandom_range(0, 1));
    end
    if (st == S_CLEAR) m_cq = 1'b0;
    a_lsb   = 1'($urandom_range(0, 1));
    s_grant = (st == S_XFER) ? (rc >= 3 + 2*W + stall) : 1'b0;
  endtask

  task automatic begin_start;
    @(posedge CLK); #1;
    start = 1'b1; abort = 1'b0; s_grant = 1'b0;
  endtask

  task automatic test_reset;
    CLR = 1'b1; start = 1'b0; abort = 1'b0; s_grant = 1'b0;
    q_lsb = 1'b0; a_lsb = 1'b0; carry = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #4;
      checks++;
      if (w_outs !== 16'h0) begin
        failures++; $display("FAIL reset_hold cyc%0d outs=%h exp=0000", i, w_outs);
      end
    end
    CLR = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #4;
      checks++;
      if (w_outs !== 16'h0 || busy !== 1'b0) begin
        failures++; $display("FAIL reset_idle cyc%0d outs=%h exp=0000", i, w_outs);
      end
    end
  endtask

  task automatic test_full(input string nm);
    int n_add_clk, n_shift, done_at, st;
    logic [15:0] e;
    n_add_clk = 0; n_shift = 0; done_at = -1;
    begin_start();
    for (int rc = 1; rc <= 37; rc++) begin
      @(posedge CLK); #1;
      st = sched(rc, 0);
      drive(st, rc, 0, 16'h0005, 16'h0000);
      #3;
      e = exp_vec(st, q_lsb, m_cq, a_lsb, s_grant, abort);
      checks++;
      if (w_outs !== e) begin
        failures++; $display("FAIL %s c%0d outs=%h exp=%h", nm, rc, w_outs, e);
      end
      if (st == S_ADD && A_CLK === 1'b1) n_add_clk++;
      if (st == S_SHIFT && A_CLK === 1'b1 && Q_CLK === 1'b1) n_shift++;
      if (done === 1'b1) done_at = rc;
    end
    checks++;
    if (n_add_clk != 2) begin
      failures++; $display("FAIL %s_add_strobes got=%0d exp=2", nm, n_add_clk);
    end
    checks++;
    if (n_shift != W) begin
      failures++; $display("FAIL %s_shift_strobes got=%0d exp=%0d", nm, n_shift, W);
    end
    checks++;
    if (done_at != 35) begin
      failures++; $display("FAIL %s_done_cycle got=%0d exp=35", nm, done_at);
    end
  endtask

  task automatic test_carry;
    int n_u, st;
    logic [15:0] e;
    n_u = 0;
    begin_start();
    for (int rc = 1; rc <= 36; rc++) begin
      @(posedge CLK); #1;
      st = sched(rc, 0);
      drive(st, rc, 0, 16'hFFFF, 16'h5A3C);
      #3;
      e = exp_vec(st, q_lsb, m_cq, a_lsb, s_grant, abort);
      checks++;
      if (w_outs !== e) begin
        failures++; $display("FAIL carry c%0d outs=%h exp=%h", rc, w_outs, e);
      end
      if (u_in === 1'b1) n_u++;
    end
    checks++;
    if (n_u != 8) begin
      failures++; $display("FAIL carry_uin_count got=%0d exp=8", n_u);
    end
  endtask

  task automatic test_grant_stall;
    int done_at, st;
    logic [15:0] e;
    done_at = -1;
    begin_start();
    for (int rc = 1; rc <= 42; rc++) begin
      @(posedge CLK); #1;
      st = sched(rc, 5);
      drive(st, rc, 5, 16'hA5C3, 16'h0F0F);
      #3;
      e = exp_vec(st, q_lsb, m_cq, a_lsb, s_grant, abort);
      checks++;
      if (w_outs !== e) begin
        failures++; $display("FAIL stall c%0d outs=%h exp=%h", rc, w_outs, e);
      end
      if (done === 1'b1) done_at = rc;
    end
    checks++;
    if (done_at != 40) begin
      failures++; $display("FAIL stall_done_cycle got=%0d exp=40", done_at);
    end
  endtask

  task automatic test_abort;
    int done_at, n_done, st, rel;
    logic [15:0] e;
    done_at = -1; n_done = 0;
    begin_start();
    for (int rc = 1; rc <= 48; rc++) begin
      @(posedge CLK); #1;
      rel = (rc <= 10) ? rc : (rc <= 12 ? 0 : rc - 12);
      st  = sched(rel, 0);
      drive(st, rel, 0, 16'h00FF, 16'h0101);
      if (rc == 10) abort = 1'b1;
      if (rc == 12) start = 1'b1;
      #3;
      e = exp_vec(st, q_lsb, m_cq, a_lsb, s_grant, abort);
      checks++;
      if (w_outs !== e) begin
        failures++; $display("FAIL abort c%0d outs=%h exp=%h", rc, w_outs, e);
      end
      if (done === 1'b1) begin done_at = rc; n_done++; end
    end
    checks++;
    if (done_at != 47 || n_done != 1) begin
      failures++; $display("FAIL abort_restart_done got=%0d n=%0d exp=47 n=1", done_at, n_done);
    end
  endtask

  task automatic test_ignored;
    int done_at, st;
    logic [15:0] e;
    done_at = -1;
    begin_start();
    for (int rc = 1; rc <= 37; rc++) begin
      @(posedge CLK); #1;
      st = sched(rc, 0);
      drive(st, rc, 0, 16'h0005, 16'hFFFF);
      s_grant = 1'b1;
      if (rc == 5 || rc == 20 || rc == 34) start = 1'b1;
      #3;
      e = exp_vec(st, q_lsb, m_cq, a_lsb, s_grant, abort);
      checks++;
      if (w_outs !== e) begin
        failures++; $display("FAIL ignored c%0d outs=%h exp=%h", rc, w_outs, e);
      end
      if (done === 1'b1) done_at = rc;
    end
    checks++;
    if (done_at != 35) begin
      failures++; $display("FAIL ignored_done_cycle got=%0d exp=35", done_at);
    end
  endtask

  task automatic test_abort_xfer;
    int n_done, st;
    logic [15:0] e;
    n_done = 0;
    begin_start();
    for (int rc = 1; rc <= 37; rc++) begin
      @(posedge CLK); #1;
      st = sched(rc, 0);
      drive(st, rc, 0, 16'h1234, 16'h4321);
      if (rc == 35) abort = 1'b1;
      #3;
      e = exp_vec(st, q_lsb, m_cq, a_lsb, s_grant, abort);
      checks++;
      if (w_outs !== e) begin
        failures++; $display("FAIL abort_xfer c%0d outs=%h exp=%h", rc, w_outs, e);
      end
      if (done === 1'b1 || ALS_mul === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      failures++; $display("FAIL abort_xfer_no_done got=%0d exp=0", n_done);
    end
  endtask

  task automatic test_abort_idle;
    begin_start();
    abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      start = 1'b0; abort = 1'b0;
      #3;
      checks++;
      if (w_outs !== 16'h0) begin
        failures++; $display("FAIL abort_start_idle cyc%0d outs=%h exp=0000", i, w_outs);
      end
    end
  endtask

  task automatic test_clr_mid;
    int st;
    logic [15:0] e;
    begin_start();
    for (int rc = 1; rc <= 12; rc++) begin
      @(posedge CLK); #1;
      st = (rc <= 8) ? sched(rc, 0) : S_IDLE;
      drive(st, rc, 0, 16'hFFFF, 16'hFFFF);
      CLR = (rc == 8);
      #3;
      e = exp_vec(st, q_lsb, m_cq, a_lsb, s_grant, abort);
      checks++;
      if (w_outs !== e) begin
        failures++; $display("FAIL clr_mid c%0d outs=%h exp=%h", rc, w_outs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full("full");
    test_carry();
    test_grant_stall();
    test_abort();
    test_ignored();
    test_abort_xfer();
    test_abort_idle();
    test_clr_mid();
    test_full("after_clr");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
